ex_mul_unit: RTL and testbench

//   Iterative 32x32 multiplier in the EX stage, fed by the ID/EX pipeline register
//   (opA, opB, mul control bit, signedness decoded from ALUCtrl).

---
 rtl/ex_mul_unit_pkg.sv | 13 +
 rtl/ex_mul_unit.sv | 124 ++++++++++++
 tb/tb_ex_mul_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_mul_unit_pkg.sv
// Shared definitions for the EX-stage iterative multiplier: FSM encoding and default sizes.
package ex_mul_unit_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mulState_t;

endpackage

// File: rtl/ex_mul_unit.sv
// Iterative shift-add multiplier for the EX stage: fixed WIDTH+1 cycle stall, low WIDTH product bits.
// Signed operands are multiplied as magnitudes and the sign is reapplied to the truncated result.
module ex_mul_unit
  import ex_mul_unit_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mul,
  input  logic             mul_signed,
  input  logic [0:WIDTH-1] opA,
  input  logic [0:WIDTH-1] opB,
  input  logic             flush,
  output logic             mul_stall,
  output logic [0:WIDTH-1] mul_result,
  output logic             mul_valid
);

  mulState_t        r_state;
  mulState_t        w_stateNext;
  logic [CNT_W-1:0] r_count;
  logic [0:WIDTH-1] r_magA;
  logic [0:WIDTH-1] r_magB;
  logic [0:WIDTH-1] r_acc;
  logic             r_neg;
  logic [0:WIDTH-1] r_mulResult;

  logic             w_start;
  logic             w_lastIter;
  logic             w_stall;
  logic [0:WIDTH-1] w_accNext;

  // Two's-complement negate when en is set; also yields |x| for signed operands.
  function automatic logic [0:WIDTH-1] condNeg(input logic [0:WIDTH-1] x, input logic en);
    return en ? -x : x;
  endfunction

  assign w_start    = mul & ~flush;
  assign w_lastIter = (r_count == CNT_W'(WIDTH - 1));
  assign w_accNext  = r_magB[WIDTH-1] ? (r_acc + r_magA) : r_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_stall     = 1'b0;
    mul_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_stateNext = ST_RUN;
          w_stall     = 1'b1;
        end
      end
      ST_RUN: begin
        if (flush) begin
          w_stateNext = ST_IDLE;
        end else begin
          w_stall = 1'b1;
          if (w_lastIter) begin
            w_stateNext = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // The finished instruction still sits in ID/EX, so mul is not re-sampled here.
        w_stateNext = ST_IDLE;
        mul_valid   = ~flush;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // While reset is held the stall must drop at once, even if ID/EX still presents a multiply.
  assign mul_stall  = w_stall & reset_n;
  assign mul_result = r_mulResult;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_magA      <= '0;
      r_magB      <= '0;
      r_acc       <= '0;
      r_neg       <= 1'b0;
      r_mulResult <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_magA  <= condNeg(opA, mul_signed & opA[0]);
            r_magB  <= condNeg(opB, mul_signed & opB[0]);
            r_neg   <= mul_signed & (opA[0] ^ opB[0]);
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        ST_RUN: begin
          if (!flush) begin
            r_acc   <= w_accNext;
            r_magA  <= r_magA << 1;
            r_magB  <= r_magB >> 1;
            r_count <= r_count + CNT_W'(1);
            if (w_lastIter) begin
              r_mulResult <= condNeg(w_accNext, r_neg);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mul_unit.sv
// Self-checking bench for ex_mul_unit: vector table run through a result scoreboard,
// plus hand-written flush, reset and back-to-back sequences.
module tb_ex_mul_unit;

  logic        clk;
  logic        reset_n;
  logic        mul;
  logic        mul_signed;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        flush;
  logic        mul_stall;
  logic [31:0] mul_result;
  logic        mul_valid;

  int errors = 0;
  int checks = 0;
  logic [31:0] expQ[$];
  logic [31:0] lastExp;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  ex_mul_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mul        (mul),
    .mul_signed (mul_signed),
    .opA        (opA),
    .opB        (opB),
    .flush      (flush),
    .mul_stall  (mul_stall),
    .mul_result (mul_result),
    .mul_valid  (mul_valid)
  );

  // 10 ns clock; inputs change and outputs are sampled around the falling edge
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log any difference
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Present one multiply (optionally on the next falling edge), push its expected product,
  // then follow it cycle by cycle until mul_valid, checking the stall window and latency
  task automatic applyStimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp, input bit align);
    int          lat;
    bit          stallOk;
    logic [31:0] e;
    if (align) @(negedge clk);
    mul        = 1'b1;
    mul_signed = sgn;
    opA        = a;
    opB        = b;
    flush      = 1'b0;
    #1;
    checkOutput("start_stall", {31'b0, mul_stall}, 32'd1);
    expQ.push_back(exp);
    stallOk = 1'b1;
    lat     = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      #1;
      if (mul_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (mul_stall !== 1'b1) stallOk = 1'b0;
    end
    checkOutput("stall_window", {31'b0, stallOk}, 32'd1);
    checkOutput("latency", lat, 32'd33);
    if (lat != 0) checkOutput("done_stall", {31'b0, mul_stall}, 32'd0);
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      if (lat != 0) begin
        checkOutput("result", mul_result, e);
        lastExp = e;
      end
    end
  endtask

  initial begin
    bit sawValid;

    vecs[0]  = '{1'b0, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
    vecs[1]  = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1};
    vecs[2]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[3]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[4]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[5]  = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
    vecs[6]  = '{1'b1, 32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};
    vecs[7]  = '{1'b0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    vecs[8]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFD6};
    vecs[9]  = '{1'b0, 32'hDEAD_BEEF, 32'h0000_0010, 32'hEADB_EEF0};
    vecs[10] = '{1'b1, 32'h0001_2345, 32'hFFFF_FFFF, 32'hFFFE_DCBB};
    vecs[11] = '{1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001};

    reset_n    = 1'b0;
    mul        = 1'b0;
    mul_signed = 1'b0;
    opA        = '0;
    opB        = '0;
    flush      = 1'b0;
    lastExp    = '0;
    sawValid   = 1'b0;

    // Reset state
    #1;
    checkOutput("reset_stall", {31'b0, mul_stall}, 32'd0);
    checkOutput("reset_valid", {31'b0, mul_valid}, 32'd0);
    checkOutput("reset_result", mul_result, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Vector table; consecutive entries also exercise back-to-back starts after DONE
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
    end

    // mul low in IDLE: nothing moves, result held
    @(negedge clk);
    mul = 1'b0;
    #1;
    checkOutput("idle_stall", {31'b0, mul_stall}, 32'd0);
    checkOutput("idle_valid", {31'b0, mul_valid}, 32'd0);
    checkOutput("idle_hold", mul_result, lastExp);

    // Flush at T+10, fresh multiply at T+11
    @(negedge clk);
    mul = 1'b1; mul_signed = 1'b0; opA = 32'd9; opB = 32'd9;
    #1;
    checkOutput("flush_start_stall", {31'b0, mul_stall}, 32'd1);
    repeat (9) begin
      @(negedge clk);
      #1;
      if (mul_valid === 1'b1) sawValid = 1'b1;
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    checkOutput("flush_stall", {31'b0, mul_stall}, 32'd0);
    checkOutput("flush_valid", {31'b0, mul_valid}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    mul   = 1'b0;
    #1;
    checkOutput("flush_idle", {31'b0, mul_stall}, 32'd0);
    checkOutput("flush_result_held", mul_result, lastExp);
    checkOutput("flush_no_valid", {31'b0, sawValid}, 32'd0);
    applyStimulus(1'b0, 32'd11, 32'd13, 32'd143, 1'b0);

    // Async reset mid-run at T+20, multiply still presented
    @(negedge clk);
    mul = 1'b1; mul_signed = 1'b0; opA = 32'h100; opB = 32'h100;
    repeat (20) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_stall", {31'b0, mul_stall}, 32'd0);
    checkOutput("midrst_valid", {31'b0, mul_valid}, 32'd0);
    checkOutput("midrst_result", mul_result, 32'd0);
    @(negedge clk);
    mul = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    lastExp = '0;
    applyStimulus(1'b1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 1'b1);

    // Explicit back-to-back pair with mul held through DONE
    @(negedge clk);
    mul = 1'b0;
    applyStimulus(1'b0, 32'd3, 32'd4, 32'h0000_000C, 1'b1);
    applyStimulus(1'b0, 32'd5, 32'd5, 32'h0000_0019, 1'b1);
    @(negedge clk);
    mul = 1'b0;
    #1;
    checkOutput("final_hold", mul_result, 32'h0000_0019);
    checkOutput("final_queue_empty", expQ.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
